bus_select_decoder: RTL and testbench

- Sequenced 5-to-32 one-hot decoder that drives the datapath bus-source and register-load strobes.
- Control logic issues a transfer request: source code, destination code and beat count.
- The block produces glitch-free registered one-hot out-enables, which feed the bus select encoder, and in-enables for the register/latch targets.
- Supports 1–4 beat block moves across GPRs R0–R15 with auto-increment and wrap; rejects illegal codes.

---
 rtl/bus_select_decoder_pkg.sv | 18 +
 rtl/bus_select_decoder_if.sv | 26 ++
 rtl/bus_select_decoder_onehot_decode5to32.sv | 9 +
 rtl/bus_select_decoder.sv | 75 +++++++
 tb/tb_bus_select_decoder.sv | 180 ++++++++++++++++++
 5 files changed

// File: rtl/bus_select_decoder_pkg.sv
// bus_select_decoder_pkg: shared code map, limits, FSM encoding and GPR increment helper
package bus_select_decoder_pkg;
    localparam logic [4:0] CODE_R0 = 5'd0, CODE_R1 = 5'd1, CODE_R2 = 5'd2, CODE_R3 = 5'd3;
    localparam logic [4:0] CODE_R4 = 5'd4, CODE_R5 = 5'd5, CODE_R6 = 5'd6, CODE_R7 = 5'd7;
    localparam logic [4:0] CODE_R8 = 5'd8, CODE_R9 = 5'd9, CODE_R10 = 5'd10, CODE_R11 = 5'd11;
    localparam logic [4:0] CODE_R12 = 5'd12, CODE_R13 = 5'd13, CODE_R14 = 5'd14, CODE_R15 = 5'd15;
    localparam logic [4:0] CODE_HI = 5'd16, CODE_LO = 5'd17, CODE_ZHI = 5'd18, CODE_ZLO = 5'd19;
    localparam logic [4:0] CODE_PC = 5'd20, CODE_MDR = 5'd21, CODE_INPORT = 5'd22, CODE_C = 5'd23;
    localparam logic [4:0] NUM_CODES = 5'd24;
    localparam logic [4:0] GPR_COUNT = 5'd16;
    localparam int MAX_BEATS = 4;
    localparam int BEAT_W = $clog2(MAX_BEATS);
    typedef enum logic {IDLE = 1'b0, DRIVE = 1'b1} state_t;
    // Block moves walk the register file and wrap from the top GPR back to R0.
    function automatic logic [4:0] gpr_inc(input logic [4:0] c);
        return (c == GPR_COUNT - 5'd1) ? CODE_R0 : c + 5'd1;
    endfunction
endpackage

// File: rtl/bus_select_decoder_if.sv
// bus_select_decoder_if: request handshake and strobe bundle between control logic and decoder
//   master: control logic (drives req_*, abort; observes ready, strobes, status)
//   slave : decoder (drives req_ready, bus_out_en, reg_in_en, busy, xfer_done, err)
interface bus_select_decoder_if;
    import bus_select_decoder_pkg::*;
    logic              req_valid;
    logic              req_ready;
    logic [4:0]        req_src;
    logic [4:0]        req_dst;
    logic              req_dst_en;
    logic [BEAT_W-1:0] req_beats;
    logic              abort;
    logic [31:0]       bus_out_en;
    logic [31:0]       reg_in_en;
    logic              busy;
    logic              xfer_done;
    logic              err;
    modport master (
        output req_valid, req_src, req_dst, req_dst_en, req_beats, abort,
        input  req_ready, bus_out_en, reg_in_en, busy, xfer_done, err
    );
    modport slave (
        input  req_valid, req_src, req_dst, req_dst_en, req_beats, abort,
        output req_ready, bus_out_en, reg_in_en, busy, xfer_done, err
    );
endinterface

// File: rtl/bus_select_decoder_onehot_decode5to32.sv
// onehot_decode5to32: combinational 5-bit code to 32-bit one-hot with enable
//   code: 5-bit select, en: gate, onehot: 1<<code when en else 0
module onehot_decode5to32 (
    input  logic [4:0]  code,
    input  logic        en,
    output logic [31:0] onehot
);
    assign onehot = en ? 32'd1 << code : '0;
endmodule

// File: rtl/bus_select_decoder.sv
// bus_select_decoder: sequenced one-hot bus-source / register-load strobe generator
//   clk, clr: clock and synchronous active-high reset
//   bus     : slave side of bus_select_decoder_if (request in, registered strobes/status out)
module bus_select_decoder
    import bus_select_decoder_pkg::*;
(
    input  logic clk,
    input  logic clr,
    bus_select_decoder_if.slave bus
);
    state_t            state, state_n;
    logic [4:0]        src, dst, src_n, dst_n;
    logic              dst_en, dst_en_n;
    logic [BEAT_W-1:0] cnt, cnt_n;
    logic              accept, illegal, drive_n;
    logic [31:0]       out_n, in_n;
    assign bus.req_ready = state == IDLE && !clr;
    assign accept = bus.req_valid && bus.req_ready;
    // Multi-beat moves auto-increment, so they are only legal within the GPR range.
    assign illegal = bus.req_src >= NUM_CODES
                  || (bus.req_dst_en && bus.req_dst >= NUM_CODES)
                  || (bus.req_beats != '0 && (bus.req_src >= GPR_COUNT
                      || (bus.req_dst_en && bus.req_dst >= GPR_COUNT)));
    always_comb begin
        state_n  = state;
        src_n    = src;
        dst_n    = dst;
        dst_en_n = dst_en;
        cnt_n    = cnt;
        if (state == IDLE) begin
            if (accept && !illegal) begin
                state_n  = DRIVE;
                src_n    = bus.req_src;
                dst_n    = bus.req_dst;
                dst_en_n = bus.req_dst_en;
                cnt_n    = bus.req_beats;
            end
        end else if (bus.abort || cnt == '0) begin
            state_n = IDLE;
        end else begin
            src_n = gpr_inc(src);
            dst_n = gpr_inc(dst);
            cnt_n = cnt - 1'b1;
        end
    end
    assign drive_n = state_n == DRIVE;
    // Strobes are decoded from next-state values so they come straight out of flops.
    onehot_decode5to32 u_src_dec (.code(src_n), .en(drive_n), .onehot(out_n));
    onehot_decode5to32 u_dst_dec (.code(dst_n), .en(drive_n && dst_en_n), .onehot(in_n));
    always_ff @(posedge clk) begin
        if (clr) begin
            state          <= IDLE;
            src            <= '0;
            dst            <= '0;
            dst_en         <= 1'b0;
            cnt            <= '0;
            bus.bus_out_en <= '0;
            bus.reg_in_en  <= '0;
            bus.busy       <= 1'b0;
            bus.xfer_done  <= 1'b0;
            bus.err        <= 1'b0;
        end else begin
            state          <= state_n;
            src            <= src_n;
            dst            <= dst_n;
            dst_en         <= dst_en_n;
            cnt            <= cnt_n;
            bus.bus_out_en <= out_n;
            bus.reg_in_en  <= in_n;
            bus.busy       <= drive_n;
            bus.xfer_done  <= drive_n && cnt_n == '0;
            bus.err        <= accept && illegal;
        end
    end
endmodule

// File: tb/tb_bus_select_decoder.sv
// tb_bus_select_decoder: scoreboard bench for bus_select_decoder
module tb_bus_select_decoder;
    typedef struct {
        logic [31:0] o;
        logic [31:0] i;
        logic        d;
        logic        e;
    } exp_t;

    logic clk = 1'b0;
    logic clr = 1'b1;
    logic mon_on = 1'b0;
    int checks = 0;
    int failures = 0;
    exp_t q[$];

    bus_select_decoder_if bus();
    bus_select_decoder dut (.clk(clk), .clr(clr), .bus(bus));

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] o, input logic [31:0] i, input logic d, input logic e);
        exp_t x;
        x.o = o; x.i = i; x.d = d; x.e = e;
        q.push_back(x);
    endtask

    task automatic send(input logic [4:0] s, input logic [4:0] d, input logic de, input logic [1:0] b);
        int n = 0;
        while (bus.req_ready !== 1'b1 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (bus.req_ready !== 1'b1) chk("ready_timeout", {31'd0, bus.req_ready}, 32'd1);
        bus.req_src = s; bus.req_dst = d; bus.req_dst_en = de; bus.req_beats = b;
        bus.req_valid = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
    endtask

    // Reference expectations for one request, used by the random stream.
    task automatic model(input logic [4:0] s, input logic [4:0] d, input logic de, input logic [1:0] b);
        logic bad;
        logic [4:0] cs, cd;
        bad = s >= 5'd24 || (de && d >= 5'd24) || (b != 2'd0 && (s >= 5'd16 || (de && d >= 5'd16)));
        if (bad) push(32'd0, 32'd0, 1'b0, 1'b1);
        else begin
            cs = s; cd = d;
            for (int k = 0; k <= int'(b); k++) begin
                push(32'd1 << cs, de ? 32'd1 << cd : 32'd0, k == int'(b), 1'b0);
                cs = (cs + 5'd1) & 5'h0f;
                cd = (cd + 5'd1) & 5'h0f;
            end
        end
    endtask

    always @(negedge clk) begin
        if (mon_on) begin
            chk("onehot_out", {31'd0, $onehot0(bus.bus_out_en) && bus.bus_out_en[31:24] == 8'd0}, 32'd1);
            chk("onehot_in", {31'd0, $onehot0(bus.reg_in_en) && bus.reg_in_en[31:24] == 8'd0}, 32'd1);
            if (bus.bus_out_en != 0 || bus.reg_in_en != 0 || bus.xfer_done || bus.err) begin
                if (q.size() == 0) chk("unexpected_output", bus.bus_out_en, 32'd0);
                else begin
                    exp_t x;
                    x = q.pop_front();
                    chk("bus_out_en", bus.bus_out_en, x.o);
                    chk("reg_in_en", bus.reg_in_en, x.i);
                    chk("xfer_done", {31'd0, bus.xfer_done}, {31'd0, x.d});
                    chk("err", {31'd0, bus.err}, {31'd0, x.e});
                    chk("busy", {31'd0, bus.busy}, {31'd0, !x.e});
                end
            end
        end
    end

    task automatic idle_zero(input string name);
        @(negedge clk);
        chk({name, "_out"}, bus.bus_out_en, 32'd0);
        chk({name, "_in"}, bus.reg_in_en, 32'd0);
        chk({name, "_done"}, {31'd0, bus.xfer_done}, 32'd0);
        chk({name, "_busy"}, {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        bus.req_valid = 1'b0; bus.req_src = '0; bus.req_dst = '0;
        bus.req_dst_en = 1'b0; bus.req_beats = '0; bus.abort = 1'b0;
        repeat (3) @(posedge clk);
        #1 mon_on = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        @(negedge clk);
        chk("rst_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("rst_err", {31'd0, bus.err}, 32'd0);
        idle_zero("rst");

        push(32'h0010_0000, 32'h0020_0000, 1'b1, 1'b0);
        send(5'd20, 5'd21, 1'b1, 2'd0);
        @(negedge clk);
        @(negedge clk);
        chk("pc_mdr_ready", {31'd0, bus.req_ready}, 32'd1);
        chk("pc_mdr_idle_out", bus.bus_out_en, 32'd0);

        push(32'h4000, 32'h4, 1'b0, 1'b0);
        push(32'h8000, 32'h8, 1'b0, 1'b0);
        push(32'h0001, 32'h10, 1'b0, 1'b0);
        push(32'h0002, 32'h20, 1'b1, 1'b0);
        send(5'd14, 5'd2, 1'b1, 2'd3);

        push(32'd0, 32'd0, 1'b0, 1'b1);
        send(5'd24, 5'd0, 1'b1, 2'd0);
        @(negedge clk);
        chk("rej_ready", {31'd0, bus.req_ready}, 32'd1);
        push(32'd0, 32'd0, 1'b0, 1'b1);
        send(5'd17, 5'd1, 1'b1, 2'd1);
        push(32'd0, 32'd0, 1'b0, 1'b1);
        send(5'd3, 5'd25, 1'b1, 2'd0);
        push(32'd0, 32'd0, 1'b0, 1'b1);
        send(5'd3, 5'd16, 1'b1, 2'd2);
        push(32'h20, 32'd0, 1'b1, 1'b0);
        send(5'd5, 5'd30, 1'b0, 2'd0);
        push(32'h0080_0000, 32'h0080_0000, 1'b1, 1'b0);
        send(5'd23, 5'd23, 1'b1, 2'd0);

        // abort while idle must not block acceptance
        bus.abort = 1'b1;
        push(32'h40, 32'h80, 1'b1, 1'b0);
        send(5'd6, 5'd7, 1'b1, 2'd0);
        bus.abort = 1'b0;

        push(32'h1, 32'h10, 1'b0, 1'b0);
        push(32'h2, 32'h20, 1'b0, 1'b0);
        send(5'd0, 5'd4, 1'b1, 2'd3);
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        idle_zero("abort");

        push(32'h100, 32'h200, 1'b0, 1'b0);
        push(32'h200, 32'h400, 1'b1, 1'b0);
        send(5'd8, 5'd9, 1'b1, 2'd1);
        @(posedge clk); #1 bus.abort = 1'b1;
        @(posedge clk); #1 bus.abort = 1'b0;
        idle_zero("abort_last");

        push(32'h400, 32'h1000, 1'b0, 1'b0);
        push(32'h800, 32'h2000, 1'b0, 1'b0);
        push(32'h1000, 32'h4000, 1'b0, 1'b0);
        send(5'd10, 5'd12, 1'b1, 2'd3);
        @(posedge clk); #1;
        @(posedge clk); #1 clr = 1'b1;
        @(posedge clk); #1 clr = 1'b0;
        idle_zero("clr_mid");
        chk("clr_mid_ready", {31'd0, bus.req_ready}, 32'd1);

        for (int r = 0; r < 200; r++) begin
            logic [4:0] s, d;
            logic de;
            logic [1:0] b;
            s = 5'($urandom_range(0, 31));
            d = 5'($urandom_range(0, 31));
            de = 1'($urandom_range(0, 1));
            b = 2'($urandom_range(0, 3));
            model(s, d, de, b);
            send(s, d, de, b);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        repeat (8) @(posedge clk);
        @(negedge clk);
        chk("queue_empty", q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
